// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_port_arbiter_if : fetch, debug and memory-port bundle for the arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
interface imem_port_arbiter_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  fetch_req;
  logic [31:0]           fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_valid;
  logic [31:0]           fetch_inst;
  logic                  fetch_err;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [31:0]           dbg_addr;
  logic [31:0]           dbg_wdata;
  logic                  dbg_gnt;
  logic                  dbg_valid;
  logic [31:0]           dbg_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  // The arbiter side
  modport slave (
    input  fetch_req, fetch_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output fetch_gnt, fetch_valid, fetch_inst, fetch_err,
    output dbg_gnt, dbg_valid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory
  modport master (
    output fetch_req, fetch_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  fetch_gnt, fetch_valid, fetch_inst, fetch_err,
    input  dbg_gnt, dbg_valid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_port_arbiter : fetch/debug sharing of a 1-cycle-latency instruction RAM
// Revision: 1.0
// ----------------------------------------------------------------------------
module imem_port_arbiter #(
  parameter int DEPTH_LOG2   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  imem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_t     resp_owner;
  logic       resp_err;
  logic       resp_we;
  logic [3:0] starve_cnt;
  logic       fetch_valid_q;
  logic       dbg_valid_q;
  logic       fetch_err_q;

  logic       force_dbg;
  logic       fetch_gnt;
  logic       dbg_gnt;
  logic       fetch_misal;
  logic       unused_bits;

  assign fetch_misal = (bus.fetch_addr[1:0] != 2'b00);

  // A debug requester that has waited STARVE_LIMIT cycles overrides fetch priority.
  always_comb begin
    force_dbg = bus.dbg_req && (starve_cnt == LIMIT);
    dbg_gnt   = !rst && bus.dbg_req && (force_dbg || !bus.fetch_req);
    fetch_gnt = !rst && bus.fetch_req && !dbg_gnt;
  end

  assign bus.fetch_gnt = fetch_gnt;
  assign bus.dbg_gnt   = dbg_gnt;

  assign bus.mem_en    = dbg_gnt || (fetch_gnt && !fetch_misal);
  assign bus.mem_we    = dbg_gnt && bus.dbg_we;
  assign bus.mem_addr  = dbg_gnt ? bus.dbg_addr[DEPTH_LOG2+1:2]
                                 : bus.fetch_addr[DEPTH_LOG2+1:2];
  assign bus.mem_wdata = bus.dbg_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_owner    <= OWN_NONE;
      resp_err      <= 1'b0;
      resp_we       <= 1'b0;
      starve_cnt    <= 4'd0;
      fetch_valid_q <= 1'b0;
      dbg_valid_q   <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      if (dbg_gnt) begin
        resp_owner <= OWN_DBG;
        resp_err   <= 1'b0;
        resp_we    <= bus.dbg_we;
      end else if (fetch_gnt) begin
        resp_owner <= OWN_FETCH;
        resp_err   <= fetch_misal;
        resp_we    <= 1'b0;
      end else begin
        resp_owner <= OWN_NONE;
        resp_err   <= 1'b0;
        resp_we    <= 1'b0;
      end
      fetch_valid_q <= fetch_gnt;
      dbg_valid_q   <= dbg_gnt;
      fetch_err_q   <= fetch_gnt && fetch_misal;

      if (!bus.dbg_req || dbg_gnt) begin
        starve_cnt <= 4'd0;
      end else if (fetch_gnt && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Read data is passed straight through from the RAM to whichever side owns the slot.
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.fetch_inst  = (resp_owner == OWN_FETCH && !resp_err) ? bus.mem_rdata : 32'd0;
  assign bus.dbg_valid   = dbg_valid_q;
  assign bus.dbg_rdata   = (resp_owner == OWN_DBG && !resp_we) ? bus.mem_rdata : 32'd0;

  assign unused_bits = ^{bus.fetch_addr[31:DEPTH_LOG2+2], bus.dbg_addr[31:DEPTH_LOG2+2],
                         bus.dbg_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_port_arbiter : randomized scoreboard bench for imem_port_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_imem_port_arbiter;
  localparam int DEPTH_LOG2 = 10;
  localparam int LIMIT      = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  typedef struct {
    int          tag;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   waited = 0;
  int   n_dgnt = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  resp_t       fq[$];
  resp_t       dq[$];

  imem_port_arbiter_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  imem_port_arbiter #(.DEPTH_LOG2(DEPTH_LOG2), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAM on the arbiter's memory port
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // One clock cycle: drive, predict from the reference rules, compare, push expectations.
  task automatic step(input logic r, input logic fr, input logic [31:0] fa,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] dd, input bit late_rst);
    bit    exp_fg, exp_dg, exp_en, misal;
    int    fw, dwi;
    resp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.dbg_req    = dr;
    bus.dbg_we     = dw;
    bus.dbg_addr   = da;
    bus.dbg_wdata  = dd;
    #2;
    exp_dg = !r && dr && ((waited == LIMIT) || !fr);
    exp_fg = !r && fr && !exp_dg;
    misal  = (fa % 4) != 0;
    exp_en = exp_dg || (exp_fg && !misal);
    fw     = int'((fa / 4) % DEPTH);
    dwi    = int'((da / 4) % DEPTH);
    chk("fetch_gnt", 32'(bus.fetch_gnt), 32'(exp_fg));
    chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(exp_dg));
    chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
    if (bus.dbg_gnt === 1'b1) n_dgnt++;
    if (exp_en) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(exp_dg ? dwi : fw));
      chk("mem_we", 32'(bus.mem_we), 32'(exp_dg && dw));
      if (exp_dg && dw) chk("mem_wdata", bus.mem_wdata, dd);
    end
    if (exp_fg) begin
      e.tag = cyc + 1;
      e.err = misal;
      e.data = misal ? 32'd0 : ref_mem[fw];
      fq.push_back(e);
    end
    if (exp_dg) begin
      e.tag = cyc + 1;
      e.err = 1'b0;
      e.data = dw ? 32'd0 : ref_mem[dwi];
      dq.push_back(e);
      if (dw) ref_mem[dwi] = dd;
    end
    if (r || !dr || exp_dg)                waited = 0;
    else if (exp_fg && waited < LIMIT)     waited++;
    if (late_rst) begin
      #3;
      rst = 1'b1;
      waited = 0;
      if (fq.size() > 0 && fq[$].tag == cyc + 1) void'(fq.pop_back());
      if (dq.size() > 0 && dq[$].tag == cyc + 1) void'(dq.pop_back());
    end
  endtask

  // Monitor: pops and compares whenever a valid is presented
  always @(negedge clk) begin
    resp_t e;
    while (fq.size() > 0 && fq[0].tag < cyc) begin
      fail_now("fetch_valid missing");
      void'(fq.pop_front());
    end
    while (dq.size() > 0 && dq[0].tag < cyc) begin
      fail_now("dbg_valid missing");
      void'(dq.pop_front());
    end
    if (bus.fetch_valid === 1'b1) begin
      if (fq.size() == 0) fail_now("fetch_valid unexpected");
      else begin
        e = fq.pop_front();
        chk("fetch_latency", 32'(cyc), 32'(e.tag));
        chk("fetch_inst", bus.fetch_inst, e.data);
        chk("fetch_err", 32'(bus.fetch_err), 32'(e.err));
      end
    end
    if (bus.dbg_valid === 1'b1) begin
      if (dq.size() == 0) fail_now("dbg_valid unexpected");
      else begin
        e = dq.pop_front();
        chk("dbg_latency", 32'(cyc), 32'(e.tag));
        chk("dbg_rdata", bus.dbg_rdata, e.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'(i) * 32'h0101_0103 ^ 32'hA5A5_0000;
      ref_mem[i] = 32'(i) * 32'h0101_0103 ^ 32'hA5A5_0000;
    end
    mem[0] = 32'h11; ref_mem[0] = 32'h11;
    mem[1] = 32'h22; ref_mem[1] = 32'h22;
    mem[2] = 32'h33; ref_mem[2] = 32'h33;

    rst = 1'b1;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

    // Reset held with fetch requesting
    step(1, 1, 32'h0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 0);
    chk("rst_dbg_valid", 32'(bus.dbg_valid), 0);
    chk("rst_fetch_inst", bus.fetch_inst, 0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 0);

    // Back-to-back fetches
    step(0, 1, 32'h0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    step(0, 1, 32'h8, 0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);

    // Debug write then fetch of the same word
    step(0, 0, 32'h0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0);
    step(0, 1, 32'h40, 0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);
    chk("raw_ref", ref_mem[16], 32'hDEAD_BEEF);

    // Both requesting continuously: 4 fetch grants then a forced debug grant
    n_dgnt = 0;
    for (int i = 0; i < 15; i++) step(0, 1, 32'(i * 4), 1, 0, 32'h80, 0, 0);
    chk("starve_dbg_gnts", 32'(n_dgnt), 32'd3);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);

    // Misaligned fetch and address wrap
    step(0, 1, 32'h6, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1000, 0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);

    // Reset right after a fetch grant discards the response
    step(0, 1, 32'h10, 0, 0, 0, 0, 1);
    step(1, 1, 32'h10, 0, 0, 0, 0, 0);
    chk("rst_discard_valid", 32'(bus.fetch_valid), 0);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);
    chk("post_rst_valid", 32'(bus.fetch_valid), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] fa, da;
      fa = $urandom;
      if ($urandom_range(0, 7) != 0) fa[1:0] = 2'b00;
      da = $urandom;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), fa,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), da, $urandom, 0);
    end

    step(0, 0, 32'h0, 0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);
    chk("fetch_queue_drained", 32'(fq.size()), 0);
    chk("dbg_queue_drained", 32'(dq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
